// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// Each transfer is framed by a slave select with setup/hold time and guarded by a completion timeout.
module spi_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [DATA_W-1:0]         o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_done,
    input  logic [DATA_W-1:0]         i_rx_data,
    output logic [NUM_REQ-1:0]        o_ss_n,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_err,
    output logic                      o_busy
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SH_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_MAX = (TIMEOUT > SH_MAX) ? TIMEOUT : SH_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETUP,
        XFER,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   last_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_nxt;
    logic               timed_out;
    logic               timed_out_nxt;

    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] ss_n_nxt;
    logic [NUM_REQ-1:0] rsp_valid_nxt;
    logic [DATA_W-1:0]  tx_data_nxt;
    logic [DATA_W-1:0]  rsp_data_nxt;
    logic               tx_valid_nxt;
    logic               err_nxt;
    logic               busy_nxt;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;
    int unsigned        cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(last) + i + 32'd1) % NUM_REQ;
            if (!win_found && i_req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Winner's TX word.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_data = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_W'(1);
        last_nxt      = last;
        owner_nxt     = owner;
        timed_out_nxt = timed_out;
        gnt_nxt       = '0;
        tx_data_nxt   = o_tx_data;
        ss_n_nxt      = o_ss_n;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = o_rsp_data;
        err_nxt       = 1'b0;
        tx_valid_nxt  = 1'b0;
        busy_nxt      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (win_found) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = NUM_REQ'(1) << win_idx;
                    tx_data_nxt   = win_data;
                    ss_n_nxt      = ~(NUM_REQ'(1) << win_idx);
                    last_nxt      = win_idx;
                    owner_nxt     = win_idx;
                    timed_out_nxt = 1'b0;
                end
            end
            GRANT: begin
                state_nxt = SETUP;
            end
            SETUP: begin
                if (cnt == CNT_W'(CS_SETUP - 1)) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                // Completion takes priority over a coincident timeout.
                if (i_tx_done) begin
                    rsp_data_nxt = i_rx_data;
                    state_nxt    = HOLD;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt       = 1'b1;
                    timed_out_nxt = 1'b1;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(CS_HOLD - 1)) begin
                    state_nxt = IDLE;
                    ss_n_nxt  = '1;
                    if (!timed_out) begin
                        rsp_valid_nxt = NUM_REQ'(1) << owner;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ss_n_nxt  = '1;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end

        // Start pulse lands on the final SETUP cycle.
        tx_valid_nxt = (state_nxt == SETUP) && (cnt_nxt == CNT_W'(CS_SETUP - 1));
        busy_nxt     = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            timed_out   <= 1'b0;
            o_gnt       <= '0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_ss_n      <= '1;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last        <= last_nxt;
            owner       <= owner_nxt;
            timed_out   <= timed_out_nxt;
            o_gnt       <= gnt_nxt;
            o_tx_data   <= tx_data_nxt;
            o_tx_valid  <= tx_valid_nxt;
            o_ss_n      <= ss_n_nxt;
            o_rsp_valid <= rsp_valid_nxt;
            o_rsp_data  <= rsp_data_nxt;
            o_err       <= err_nxt;
            o_busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; requester k owns slave-select line k.
REQ-002 Parameter DATA_W, default 8: transfer word width.
REQ-003 Parameter CS_SETUP, default 2: cycles slave select is low before the transfer starts (>=1).
REQ-004 Parameter CS_HOLD, default 2: cycles slave select stays low after the transfer completes (>=1).
REQ-005 Parameter TIMEOUT, default 64: maximum cycles to wait for transfer completion.
REQ-006 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 i_rst  input  1  reset, asynchronous, active-low.
REQ-008 i_req  input  NUM_REQ  per-requester transfer request, level, held until granted.
REQ-009 i_req_data  input  NUM_REQ*DATA_W  packed TX words; slice k belongs to requester k.
REQ-010 o_gnt  output  NUM_REQ  one-hot, one-cycle pulse when requester k's word is captured.
REQ-011 o_tx_data  output  DATA_W  word presented to the SPI master.
REQ-012 o_tx_valid  output  1  one-cycle start pulse to the SPI master.
REQ-013 i_tx_done  input  1  one-cycle pulse from the SPI master when the word has shifted out.
REQ-014 i_rx_data  input  DATA_W  received word, valid while i_tx_done is high.
REQ-015 o_ss_n  output  NUM_REQ  active-low slave selects, at most one low at any time.
REQ-016 o_rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse returning the RX word to the owning requester.
REQ-017 o_rsp_data  output  DATA_W  RX word, valid while any o_rsp_valid bit is high.
REQ-018 o_err  output  1  one-cycle pulse on transfer timeout.
REQ-019 o_busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, GRANT, SETUP, XFER, HOLD.
REQ-021 IDLE: if any i_req bit is high, select the winner by round-robin and go to GRANT; otherwise stay in IDLE.
REQ-022 Round-robin: search starts at (last_granted+1) mod NUM_REQ; last_granted resets to NUM_REQ-1, so requester 0 wins first.
REQ-023 GRANT (1 cycle): pulse o_gnt[winner], capture the winner's i_req_data slice into o_tx_data, drive o_ss_n[winner] low, update last_granted, go to SETUP.
REQ-024 SETUP: count CS_SETUP cycles; on the last cycle pulse o_tx_valid and go to XFER.
REQ-025 XFER: on i_tx_done, register i_rx_data and go to HOLD; if TIMEOUT cycles elapse without i_tx_done, pulse o_err and go to HOLD with the RX register unchanged.
REQ-026 HOLD: count CS_HOLD cycles; on exit, drive o_ss_n all-high, pulse o_rsp_valid[owner] (suppressed after a timeout), and go to IDLE.
REQ-027 o_tx_data and the owner index SHALL remain stable from GRANT through HOLD.
REQ-028 i_tx_done outside XFER SHALL be ignored.
REQ-029 Changes to i_req or i_req_data after the grant SHALL have no effect on the current transfer.
REQ-030 At least one IDLE cycle SHALL separate consecutive transfers, so grant-to-grant spacing is >= CS_SETUP+CS_HOLD+3 cycles.
REQ-031 i_tx_done and a timeout in the same cycle: completion wins and o_err is not pulsed.
REQ-032 The timeout and setup/hold counters SHALL be wide enough for their parameter values and SHALL clear on every state entry.

Reset
REQ-033 While i_rst is low: state=IDLE, o_ss_n all-high, and o_gnt, o_tx_valid, o_rsp_valid, o_err, o_busy, o_tx_data, o_rsp_data and all counters are 0.
REQ-034 Asserting reset mid-transfer SHALL raise o_ss_n immediately (asynchronously) and emit no o_rsp_valid.
REQ-035 After reset release, the first arbitration SHALL occur on the first clock edge that sees i_req nonzero.

Verification
REQ-036 Single transfer: i_req=0001, data0=0xA5; SPI model returns 0x3C after 16 cycles -> o_gnt=0001, o_ss_n[0] low 2 cycles before o_tx_valid, o_rsp_valid=0001 with 0x3C, o_ss_n high 2 cycles after i_tx_done.
REQ-037 Fairness: i_req=1111 held with requests reasserted after each grant -> grant order 0,1,2,3,0; at most one o_ss_n bit low at any time.
REQ-038 Timeout: i_req=0100 with i_tx_done never pulsed -> o_err pulses exactly 64 cycles after entering XFER, no o_rsp_valid, FSM returns to IDLE.
REQ-039 Boundary: i_tx_done arrives on the 64th XFER cycle -> normal response and no o_err; a stray i_tx_done during SETUP is ignored.
REQ-040 Reset mid-XFER -> o_ss_n=1111 with no clock edge, all outputs 0; a new i_req=0010 after release is granted to requester 1.
REQ-041 Data isolation: change i_req_data to 0xFF one cycle after the grant -> o_tx_data keeps the captured value through HOLD.
